// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : music_pkg
//  Description : Shared constants, state encoding and the note-to-half-period
//                arithmetic for the music player sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

    // Note code space: 0 is a rest, 1..48 are tuned notes (22 = A4).
    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_MIN  = 8'd1;
    localparam logic [7:0] NOTE_MAX  = 8'd48;

    // Sequencer states.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_PLAY  = 2'd3;

    // Half-period in clock cycles of note code n (equal temperament around
    // A4 = 440 Hz at code 22), rounded to the nearest cycle. Only evaluated
    // during elaboration; codes outside 1..48 map to 0 (silent).
    function automatic int half_period(input int clk_hz, input int note);
        real f;
        if (note < 1 || note > 48) begin
            return 0;
        end
        f = 440.0 * (2.0 ** ((real'(note) - 22.0) / 12.0));
        return $rtoi((real'(clk_hz) / (2.0 * f)) + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_period_lut.sv
`default_nettype none
// ============================================================================
//  Module      : note_period_lut
//  Description : Combinational note code -> square-wave half-period table,
//                built at elaboration from the clock frequency. Returns 0 for
//                rests and out-of-range codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_period_lut
    import music_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int HALF_W = 19
) (
    input  logic [7:0]        i_note,
    output logic [HALF_W-1:0] o_half
);

    logic [HALF_W-1:0] w_table [0:63];

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_table
            assign w_table[gi] = HALF_W'(half_period(CLK_HZ, gi));
        end
    endgenerate

    // Select the table entry only for tuned codes; everything else is silent.
    always_comb begin
        o_half = '0;
        if (i_note >= NOTE_MIN && i_note <= NOTE_MAX) begin
            o_half = w_table[i_note[5:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/music_player.sv
`default_nettype none
// ============================================================================
//  Module      : music_player
//  Description : Song sequencer. Steps a synchronous note ROM once per beat,
//                prefetching the next entry to hide the ROM latency, and
//                drives a square-wave buzzer at the current note's pitch.
//                Repeated identical entries play legato.
//  Revision    : 1.0 - initial release
// ============================================================================
module music_player
    import music_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int SONG_LEN    = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       loop,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic [7:0] note_cur,
    output logic       buzzer,
    output logic       playing,
    output logic       done
);

    localparam int c_BEAT_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    // The lowest note has the longest half-period.
    localparam int c_HALF_MAX = half_period(CLK_HZ, 1);
    localparam int c_HALF_W   = $clog2(c_HALF_MAX + 1);

    localparam logic [c_BEAT_W-1:0] c_BEAT_PREF = c_BEAT_W'(BEAT_CYCLES - 3);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [7:0]          c_ADDR_LAST = 8'(SONG_LEN - 1);

    logic [1:0]          r_state;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [c_HALF_W-1:0] r_tone_cnt;
    logic                r_stop;      // song ends after the current (last) entry

    logic [c_HALF_W-1:0] w_half;
    logic                w_beat_adv;
    logic                w_entry_end;
    logic                w_load_note;
    logic                w_stop_end;

    note_period_lut #(
        .CLK_HZ (CLK_HZ),
        .HALF_W (c_HALF_W)
    ) u_lut (
        .i_note (note_cur),
        .o_half (w_half)
    );

    assign playing     = (r_state != c_ST_IDLE);
    assign w_beat_adv  = (r_state == c_ST_PLAY) && !pause;
    assign w_entry_end = w_beat_adv && (r_beat_cnt == c_BEAT_LAST);
    // The first note is taken in WAIT even when paused; later notes only at
    // an unpaused beat end.
    assign w_load_note = (r_state == c_ST_WAIT) || (w_entry_end && !r_stop);
    assign w_stop_end  = w_entry_end && r_stop;

    // Sequencer: state, beat timing, ROM address prefetch and note latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            rom_addr   <= 8'd0;
            note_cur   <= NOTE_REST;
            r_beat_cnt <= '0;
            r_stop     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state  <= c_ST_FETCH;
                        rom_addr <= 8'd0;
                        r_stop   <= 1'b0;
                    end
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_state    <= c_ST_PLAY;
                    note_cur   <= rom_note;
                    r_beat_cnt <= '0;
                end
                c_ST_PLAY: begin
                    if (!pause) begin
                        if (r_beat_cnt == c_BEAT_LAST) begin
                            r_beat_cnt <= '0;
                            if (r_stop) begin
                                r_state  <= c_ST_IDLE;
                                done     <= 1'b1;
                                note_cur <= NOTE_REST;
                                rom_addr <= 8'd0;
                                r_stop   <= 1'b0;
                            end else begin
                                note_cur <= rom_note;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                        end
                        // Address changes two cycles before the beat ends so
                        // the ROM output is ready when the note is latched.
                        if (r_beat_cnt == c_BEAT_PREF) begin
                            if (rom_addr == c_ADDR_LAST) begin
                                if (loop) begin
                                    rom_addr <= 8'd0;
                                end else begin
                                    r_stop <= 1'b1;
                                end
                            end else begin
                                rom_addr <= rom_addr + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Tone generator: toggles the buzzer every half-period of the sounding
    // note; a changed note restarts the phase, an identical one continues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tone_cnt <= '0;
            buzzer     <= 1'b0;
        end else if ((w_load_note && (rom_note != note_cur)) || w_stop_end) begin
            r_tone_cnt <= '0;
            buzzer     <= 1'b0;
        end else if (w_half == '0) begin
            r_tone_cnt <= '0;
            buzzer     <= 1'b0;
        end else if (pause && (r_state != c_ST_IDLE)) begin
            buzzer <= 1'b0;
        end else if (r_tone_cnt == (w_half - c_HALF_W'(1))) begin
            r_tone_cnt <= '0;
            buzzer     <= ~buzzer;
        end else begin
            r_tone_cnt <= r_tone_cnt + c_HALF_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_music_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_music_player
//  Description : Randomised bench for music_player against a time-based
//                reference model (song position from elapsed unpaused cycles,
//                buzzer phase from arithmetic on the note's half-period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_music_player;

    localparam int CLK_HZ = 1_000_000;
    localparam int BEAT   = 4000;
    localparam int LEN    = 8;

    logic       clk = 1'b0;
    logic       rst, start, pause, loop;
    logic [7:0] rom_addr, rom_note, note_cur;
    logic       buzzer, playing, done;

    logic [7:0] rom [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_mode  = 0;   // 0 idle, 1 fetch, 2 wait, 3 play
    int m_t     = 0;   // unpaused play cycles since the song started
    int m_run   = 0;   // m_t at which the current note run began
    int m_base  = 0;   // half-period count at the last buzzer clear by pause
    int m_zero  = 0;   // buzzer forced low by pause at the last edge
    int m_stop  = 0;
    int m_done  = 0;

    int cyc      = 0;
    int p_play   = 0;
    int n_done   = 0;
    int done_cyc = 0;
    int n_wrap   = 0;
    int prev_addr = 0;

    always #5 clk = ~clk;

    // Behavioural synchronous ROM, one cycle of latency.
    always @(posedge clk) rom_note <= rom[rom_addr];

    music_player #(
        .CLK_HZ      (CLK_HZ),
        .BEAT_CYCLES (BEAT),
        .SONG_LEN    (LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_note (rom_note),
        .note_cur (note_cur),
        .buzzer   (buzzer),
        .playing  (playing),
        .done     (done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int half_of(input int n);
        real f;
        if (n < 1 || n > 48) return 0;
        f = 440.0 * (2.0 ** ((n - 22) / 12.0));
        return $rtoi(CLK_HZ / (2.0 * f) + 0.5);
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic s, input logic p, input logic l);
        int pos, e, a, h;
        m_done = 0;
        if (r) begin
            m_mode = 0; m_stop = 0; m_zero = 0;
            return;
        end
        case (m_mode)
            0: if (s) m_mode = 1;
            1: m_mode = 2;
            2: begin
                m_mode = 3; m_t = 0; m_run = 0; m_base = 0; m_zero = 0; m_stop = 0;
            end
            default: begin
                e = m_t / BEAT; pos = m_t % BEAT; a = e % LEN;
                if (p) begin
                    p_play++;
                    m_zero = 1;
                    h = half_of(int'(rom[a]));
                    if (h > 0) m_base = (m_t - m_run) / h;
                end else begin
                    m_zero = 0;
                    if (pos == BEAT - 3 && a == LEN - 1) m_stop = l ? 0 : 1;
                    if (pos == BEAT - 1 && m_stop != 0) begin
                        m_mode = 0; m_stop = 0; m_done = 1;
                    end else begin
                        m_t++;
                        if (pos == BEAT - 1 && rom[(a + 1) % LEN] != rom[a]) begin
                            m_run = m_t; m_base = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    // Compare all outputs mid-cycle, then apply inputs for the next edge.
    task automatic step(input logic r, input logic s, input logic p, input logic l);
        int pos, e, a, h, en, ea, eb;
        @(negedge clk);
        en = 0; ea = 0; eb = 0;
        if (m_mode == 3) begin
            e = m_t / BEAT; pos = m_t % BEAT; a = e % LEN;
            en = int'(rom[a]);
            ea = a;
            if (pos >= BEAT - 2 && m_stop == 0) ea = (a + 1) % LEN;
            h = half_of(en);
            if (h > 0 && m_zero == 0) eb = (((m_t - m_run) / h - m_base) % 2);
        end
        chk("note_cur", int'(note_cur), en);
        chk("rom_addr", int'(rom_addr), ea);
        chk("buzzer",   int'(buzzer),   eb);
        chk("playing",  int'(playing),  (m_mode != 0) ? 1 : 0);
        chk("done",     int'(done),     m_done);
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (playing && prev_addr == LEN - 1 && rom_addr == 8'd0) n_wrap++;
        prev_addr = int'(rom_addr);
        rst = r; start = s; pause = p; loop = l;
        @(posedge clk);
        cyc++;
        model_edge(r, s, p, l);
    endtask

    initial begin
        int c0, pleft, n_done_a;
        logic s, p;
        rst = 1'b1; start = 1'b0; pause = 1'b0; loop = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 48));
        rom[0] = 8'd33; rom[1] = 8'd33; rom[2] = 8'd32; rom[3] = 8'd22;
        rom[4] = 8'd0;  rom[5] = 8'd34;
        rom[6] = ($urandom_range(0, 1) == 0) ? 8'd34 : 8'($urandom_range(1, 48));
        rom[7] = ($urandom_range(0, 3) == 0) ? 8'd60 : 8'($urandom_range(1, 48));

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        // rst wins over start; pause in idle changes nothing
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Run A: no loop, random pauses (one long pause mid-beat), stray starts
        step(1'b0, 1'b1, 1'b0, 1'b0);
        c0 = cyc; p_play = 0; n_done = 0; pleft = 0;
        for (int k = 0; k < 45000 && n_done == 0; k++) begin
            if (k == 6000) pleft = 1000;
            else if (pleft == 0 && $urandom_range(0, 2999) == 0) pleft = $urandom_range(1, 40);
            p = (pleft > 0);
            if (pleft > 0) pleft--;
            s = (m_mode == 3) && ($urandom_range(0, 1999) == 0);
            step(1'b0, s, p, 1'b0);
        end
        chk("done_seen", n_done, 1);
        chk("done_delay", done_cyc - c0, 8 * BEAT + 2 + p_play);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'(k % 7 == 0), 1'b0);
        chk("done_once", n_done, 1);
        n_done_a = n_done;

        // Run B: looping song, then reset mid-song and replay
        for (int i = 0; i < LEN; i++) begin
            rom[i] = ($urandom_range(0, 3) == 0 && i > 0) ? rom[i-1] : 8'($urandom_range(0, 50));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        pleft = 0;
        for (int k = 0; k < 33500; k++) begin
            if (pleft == 0 && $urandom_range(0, 3999) == 0) pleft = $urandom_range(1, 60);
            p = (pleft > 0);
            if (pleft > 0) pleft--;
            s = ($urandom_range(0, 1999) == 0);
            step(1'b0, s, p, 1'b1);
        end
        chk("loop_wrap", (n_wrap >= 1) ? 1 : 0, 1);
        chk("loop_no_done", n_done - n_done_a, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_playing", int'(playing), 0);
        chk("rst_note", int'(note_cur), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4500; k++) step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
